// File: rtl/axi_burst_slave.sv
// rtl/axi_burst_slave.sv - AXI3 burst responder backed by an internal word RAM
//
// Stands in for the DDR port behind the stream-to-AXI bridge. It accepts
// INCR bursts of up to 16 beats into a 2^MEM_AW x 32-bit RAM and returns
// them on read bursts. The write and read channels are independent state
// machines sharing one clock.
//
// Optional feature macro: AXI_SLAVE_ERR_EN
//   defined   : requests with a bad size, burst type, misalignment or
//               out-of-range address are answered with SLVERR; flagged
//               writes store nothing and flagged reads return zero data.
//   undefined : size, burst, alignment and upper address bits are ignored.
//
// Ports
//   AXI_clk, rst                 clock, synchronous active-high reset
//   AXI_aw*                      write address channel (addr/id/len/size/burst)
//   AXI_w*                       write data channel (data/strb/last)
//   AXI_b*                       write response channel (id/resp)
//   AXI_ar*                      read address channel (addr/id/len/size/burst)
//   AXI_r*                       read data channel (data/id/resp/last)
//   wr_bursts, rd_bursts         completed write / read burst counters

module axi_burst_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        AXI_clk,
    input  logic        rst,

    input  logic [31:0] AXI_awaddr,
    input  logic [5:0]  AXI_awid,
    input  logic [3:0]  AXI_awlen,
    input  logic [2:0]  AXI_awsize,
    input  logic [1:0]  AXI_awburst,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,

    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wlast,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,

    output logic [5:0]  AXI_bid,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,

    input  logic [31:0] AXI_araddr,
    input  logic [5:0]  AXI_arid,
    input  logic [3:0]  AXI_arlen,
    input  logic [2:0]  AXI_arsize,
    input  logic [1:0]  AXI_arburst,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,

    output logic [31:0] AXI_rdata,
    output logic [5:0]  AXI_rid,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rlast,
    output logic        AXI_rvalid,
    input  logic        AXI_rready,

    output logic [31:0] wr_bursts,
    output logic [31:0] rd_bursts
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Storage: not reset, contents survive rst.
    logic [31:0] mem [0:(1<<MEM_AW)-1];

    // Request error classification
    logic aw_err;
    logic ar_err;

`ifdef AXI_SLAVE_ERR_EN
    function automatic logic req_bad(input logic [31:0] addr,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst);
        return (size != 3'b010) || (burst != 2'b01) ||
               (addr[31:MEM_AW+2] != '0) || (addr[1:0] != 2'b00);
    endfunction

    assign aw_err = req_bad(AXI_awaddr, AXI_awsize, AXI_awburst);
    assign ar_err = req_bad(AXI_araddr, AXI_arsize, AXI_arburst);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;

    // Request fields that carry no meaning in this build.
    logic unused_req_bits;
    assign unused_req_bits = ^{AXI_awaddr[31:MEM_AW+2], AXI_awaddr[1:0],
                               AXI_awsize, AXI_awburst,
                               AXI_araddr[31:MEM_AW+2], AXI_araddr[1:0],
                               AXI_arsize, AXI_arburst};
`endif

    // Write channel
    w_state_t          w_state;
    logic [MEM_AW-1:0] wr_idx;
    logic [3:0]        wr_cnt;
    logic [3:0]        wr_len;
    logic              wr_err;
    logic              wr_wlast_err;
    logic              wr_last_beat;
    logic              wlast_bad;
    logic              mem_we;

    assign wr_last_beat = (wr_cnt == wr_len);
    // The burst length is authoritative; wlast only grades the response.
    assign wlast_bad    = (AXI_wlast != wr_last_beat);
    // Gated by rst so a beat presented in the reset cycle is not committed.
    assign mem_we       = (w_state == W_DATA) && AXI_wvalid && !wr_err && !rst;

    always_ff @(posedge AXI_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (AXI_wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= AXI_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            AXI_awready  <= 1'b1;
            AXI_wready   <= 1'b0;
            AXI_bvalid   <= 1'b0;
            AXI_bid      <= '0;
            AXI_bresp    <= RESP_OKAY;
            wr_bursts    <= '0;
            wr_idx       <= '0;
            wr_cnt       <= '0;
            wr_len       <= '0;
            wr_err       <= 1'b0;
            wr_wlast_err <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AXI_awvalid && AXI_awready) begin
                        wr_idx       <= AXI_awaddr[MEM_AW+1:2];
                        AXI_bid      <= AXI_awid;
                        wr_len       <= AXI_awlen;
                        wr_cnt       <= '0;
                        wr_err       <= aw_err;
                        wr_wlast_err <= 1'b0;
                        AXI_awready  <= 1'b0;
                        AXI_wready   <= 1'b1;
                        w_state      <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (AXI_wvalid) begin
                        wr_idx <= wr_idx + 1'b1;
                        wr_cnt <= wr_cnt + 4'd1;
                        if (wlast_bad) begin
                            wr_wlast_err <= 1'b1;
                        end
                        if (wr_last_beat) begin
                            AXI_wready <= 1'b0;
                            AXI_bvalid <= 1'b1;
                            AXI_bresp  <= (wr_err || wr_wlast_err || wlast_bad)
                                          ? RESP_SLVERR : RESP_OKAY;
                            w_state    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (AXI_bready) begin
                        AXI_bvalid  <= 1'b0;
                        AXI_awready <= 1'b1;
                        wr_bursts   <= wr_bursts + 32'd1;
                        w_state     <= W_IDLE;
                    end
                end
                default: begin
                    w_state     <= W_IDLE;
                    AXI_awready <= 1'b1;
                    AXI_wready  <= 1'b0;
                    AXI_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: every beat takes a fetch cycle, then a presentation
    // cycle, so a full-rate master sees one beat every two cycles.
    r_state_t          r_state;
    logic [MEM_AW-1:0] rd_idx;
    logic [3:0]        rd_beat;
    logic [3:0]        rd_len;
    logic              rd_err;

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            AXI_arready <= 1'b1;
            AXI_rvalid  <= 1'b0;
            AXI_rlast   <= 1'b0;
            AXI_rid     <= '0;
            AXI_rresp   <= RESP_OKAY;
            AXI_rdata   <= '0;
            rd_bursts   <= '0;
            rd_idx      <= '0;
            rd_beat     <= '0;
            rd_len      <= '0;
            rd_err      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (AXI_arvalid && AXI_arready) begin
                        rd_idx      <= AXI_araddr[MEM_AW+1:2];
                        AXI_rid     <= AXI_arid;
                        rd_len      <= AXI_arlen;
                        rd_beat     <= '0;
                        rd_err      <= ar_err;
                        AXI_arready <= 1'b0;
                        r_state     <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Same-edge write to this word is not visible: read-first.
                    AXI_rdata  <= rd_err ? 32'd0 : mem[rd_idx];
                    AXI_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    AXI_rlast  <= (rd_beat == rd_len);
                    AXI_rvalid <= 1'b1;
                    r_state    <= R_DATA;
                end
                R_DATA: begin
                    if (AXI_rready) begin
                        AXI_rvalid <= 1'b0;
                        AXI_rlast  <= 1'b0;
                        if (AXI_rlast) begin
                            AXI_arready <= 1'b1;
                            rd_bursts   <= rd_bursts + 32'd1;
                            r_state     <= R_IDLE;
                        end else begin
                            rd_idx  <= rd_idx + 1'b1;
                            rd_beat <= rd_beat + 4'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state     <= R_IDLE;
                    AXI_arready <= 1'b1;
                    AXI_rvalid  <= 1'b0;
                    AXI_rlast   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_slave.sv
// tb/tb_axi_burst_slave.sv - directed self-checking bench for axi_burst_slave

module tb_axi_burst_slave;

    logic        AXI_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] AXI_awaddr = '0;
    logic [5:0]  AXI_awid = '0;
    logic [3:0]  AXI_awlen = '0;
    logic [2:0]  AXI_awsize = 3'b010;
    logic [1:0]  AXI_awburst = 2'b01;
    logic        AXI_awvalid = 1'b0;
    logic        AXI_awready;
    logic [31:0] AXI_wdata = '0;
    logic [3:0]  AXI_wstrb = '0;
    logic        AXI_wlast = 1'b0;
    logic        AXI_wvalid = 1'b0;
    logic        AXI_wready;
    logic [5:0]  AXI_bid;
    logic [1:0]  AXI_bresp;
    logic        AXI_bvalid;
    logic        AXI_bready = 1'b0;
    logic [31:0] AXI_araddr = '0;
    logic [5:0]  AXI_arid = '0;
    logic [3:0]  AXI_arlen = '0;
    logic [2:0]  AXI_arsize = 3'b010;
    logic [1:0]  AXI_arburst = 2'b01;
    logic        AXI_arvalid = 1'b0;
    logic        AXI_arready;
    logic [31:0] AXI_rdata;
    logic [5:0]  AXI_rid;
    logic [1:0]  AXI_rresp;
    logic        AXI_rlast;
    logic        AXI_rvalid;
    logic        AXI_rready = 1'b0;
    logic [31:0] wr_bursts;
    logic [31:0] rd_bursts;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [0:1023];
    logic [31:0] wbuf [0:15];
    logic [31:0] rbuf [0:15];

    axi_burst_slave #(.MEM_AW(10)) dut (
        .AXI_clk(AXI_clk), .rst(rst),
        .AXI_awaddr(AXI_awaddr), .AXI_awid(AXI_awid), .AXI_awlen(AXI_awlen),
        .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst),
        .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
        .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wlast(AXI_wlast),
        .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
        .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp),
        .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
        .AXI_araddr(AXI_araddr), .AXI_arid(AXI_arid), .AXI_arlen(AXI_arlen),
        .AXI_arsize(AXI_arsize), .AXI_arburst(AXI_arburst),
        .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
        .AXI_rdata(AXI_rdata), .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp),
        .AXI_rlast(AXI_rlast), .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready),
        .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
    );

    always #5 AXI_clk = ~AXI_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one write burst from wbuf; inputs change on falling edges.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [3:0] strb, input int wlast_beat,
                               input int bready_delay, input logic [5:0] id,
                               input logic [2:0] size, input logic do_write,
                               input logic [1:0] exp_bresp);
        int t;
        logic [9:0] idx;
        @(negedge AXI_clk);
        AXI_awaddr = addr; AXI_awid = id; AXI_awlen = len;
        AXI_awsize = size; AXI_awburst = 2'b01; AXI_awvalid = 1'b1;
        t = 0;
        while (!AXI_awready && t < 50) begin @(negedge AXI_clk); t++; end
        check("aw_handshake", AXI_awready, 1);
        @(posedge AXI_clk);
        @(negedge AXI_clk);
        AXI_awvalid = 1'b0;
        check("wready_after_aw", AXI_wready, 1);
        check("awready_low_in_burst", AXI_awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            AXI_wdata = wbuf[i]; AXI_wstrb = strb;
            AXI_wlast = (i == wlast_beat); AXI_wvalid = 1'b1;
            t = 0;
            while (!AXI_wready && t < 50) begin @(negedge AXI_clk); t++; end
            check("w_handshake", AXI_wready, 1);
            @(posedge AXI_clk);
            if (do_write) begin
                idx = addr[11:2] + 10'(i);
                for (int b = 0; b < 4; b++)
                    if (strb[b]) exp_mem[idx][8*b +: 8] = wbuf[i][8*b +: 8];
            end
            @(negedge AXI_clk);
        end
        AXI_wvalid = 1'b0; AXI_wlast = 1'b0;
        check("bvalid_after_last_w", AXI_bvalid, 1);
        check("bid", AXI_bid, id);
        check("bresp", AXI_bresp, exp_bresp);
        for (int d = 0; d < bready_delay; d++) begin
            @(negedge AXI_clk);
            check("bvalid_held", AXI_bvalid, 1);
            check("bid_held", AXI_bid, id);
            check("bresp_held", AXI_bresp, exp_bresp);
        end
        AXI_bready = 1'b1;
        @(posedge AXI_clk);
        @(negedge AXI_clk);
        AXI_bready = 1'b0;
        check("bvalid_cleared", AXI_bvalid, 0);
        check("awready_back", AXI_awready, 1);
    endtask

    // Reads one burst into rbuf, comparing each beat against the model.
    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [5:0] id,
                              input logic toggle, input logic zero_data,
                              input logic [1:0] exp_rresp);
        int t, beat, cyc;
        logic first, held, rdy;
        logic [31:0] s_data;
        logic s_last;
        logic [9:0] idx;
        @(negedge AXI_clk);
        AXI_araddr = addr; AXI_arid = id; AXI_arlen = len;
        AXI_arsize = size; AXI_arburst = 2'b01; AXI_arvalid = 1'b1;
        t = 0;
        while (!AXI_arready && t < 50) begin @(negedge AXI_clk); t++; end
        check("ar_handshake", AXI_arready, 1);
        @(posedge AXI_clk);
        @(negedge AXI_clk);
        AXI_arvalid = 1'b0;
        check("rvalid_not_yet", AXI_rvalid, 0);
        beat = 0; cyc = 1; first = 1'b1; held = 1'b0;
        s_data = '0; s_last = 1'b0;
        while (beat <= int'(len) && cyc < 400) begin
            if (held) check("rvalid_held", AXI_rvalid, 1);
            if (AXI_rvalid) begin
                if (first) begin
                    check("r_first_latency", cyc, 2);
                    first = 1'b0;
                end
                if (held) begin
                    check("rdata_held", AXI_rdata, s_data);
                    check("rlast_held", AXI_rlast, s_last);
                end
                rdy = !toggle || ((cyc % 3) != 1);
                AXI_rready = rdy;
                if (rdy) begin
                    idx = addr[11:2] + 10'(beat);
                    check("rdata", AXI_rdata, zero_data ? 32'd0 : exp_mem[idx]);
                    check("rlast", AXI_rlast, (beat == int'(len)));
                    check("rid", AXI_rid, id);
                    check("rresp", AXI_rresp, exp_rresp);
                    rbuf[beat] = AXI_rdata;
                    beat++;
                    held = 1'b0;
                end else begin
                    s_data = AXI_rdata; s_last = AXI_rlast;
                    held = 1'b1;
                end
            end else begin
                AXI_rready = 1'b0;
            end
            @(negedge AXI_clk);
            cyc++;
        end
        AXI_rready = 1'b0;
        check("r_beat_count", beat, int'(len) + 1);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge AXI_clk);
        @(negedge AXI_clk);
        check("rst_awready", AXI_awready, 1);
        check("rst_wready", AXI_wready, 0);
        check("rst_bvalid", AXI_bvalid, 0);
        check("rst_bid", AXI_bid, 0);
        check("rst_bresp", AXI_bresp, 0);
        check("rst_arready", AXI_arready, 1);
        check("rst_rvalid", AXI_rvalid, 0);
        check("rst_rlast", AXI_rlast, 0);
        check("rst_rid", AXI_rid, 0);
        check("rst_rresp", AXI_rresp, 0);
        check("rst_rdata", AXI_rdata, 0);
        check("rst_wr_bursts", wr_bursts, 0);
        check("rst_rd_bursts", rd_bursts, 0);
        rst = 1'b0;

        // 16-beat burst at 0x40 with data 0..15
        for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
        write_burst(32'h40, 4'd15, 4'hF, 15, 0, 6'h2A, 3'b010, 1'b1, 2'b00);
        read_burst(32'h40, 4'd15, 3'b010, 6'h15, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 16; i++) check("seq_readback", rbuf[i], 32'(i));
        check("wr_bursts_1", wr_bursts, 1);
        check("rd_bursts_1", rd_bursts, 1);

        // Byte-strobe merge at byte address 0x100
        wbuf[0] = 32'hAABBCCDD;
        write_burst(32'h100, 4'd0, 4'hF, 0, 0, 6'h05, 3'b010, 1'b1, 2'b00);
        wbuf[0] = 32'h11223344;
        write_burst(32'h100, 4'd0, 4'b0101, 0, 0, 6'h06, 3'b010, 1'b1, 2'b00);
        read_burst(32'h100, 4'd0, 3'b010, 6'h07, 1'b0, 1'b0, 2'b00);
        check("strb_merge", rbuf[0], 32'hAA22CC44);

        // Wrap from word 1020 to word 11; slow bready, toggling rready
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        write_burst(32'hFF0, 4'd15, 4'hF, 15, 5, 6'h3F, 3'b010, 1'b1, 2'b00);
        read_burst(32'hFF0, 4'd15, 3'b010, 6'h21, 1'b1, 1'b0, 2'b00);
        read_burst(32'h0, 4'd11, 3'b010, 6'h22, 1'b0, 1'b0, 2'b00);
        check("wrap_word0", rbuf[0], 32'hC0DE0004);
        check("wrap_word11", rbuf[11], 32'hC0DE000F);

        // Out-of-range address and bad read size
        wbuf[0] = 32'h5A5A5A5A;
`ifdef AXI_SLAVE_ERR_EN
        write_burst(32'h10000, 4'd0, 4'hF, 0, 0, 6'h11, 3'b010, 1'b0, 2'b10);
        read_burst(32'h0, 4'd0, 3'b010, 6'h12, 1'b0, 1'b0, 2'b00);
        check("err_write_no_store", rbuf[0], 32'hC0DE0004);
        read_burst(32'h40, 4'd15, 3'b001, 6'h13, 1'b0, 1'b1, 2'b10);
`else
        write_burst(32'h10000, 4'd0, 4'hF, 0, 0, 6'h11, 3'b010, 1'b1, 2'b00);
        read_burst(32'h0, 4'd0, 3'b010, 6'h12, 1'b0, 1'b0, 2'b00);
        check("alias_word0", rbuf[0], 32'h5A5A5A5A);
        read_burst(32'h40, 4'd15, 3'b001, 6'h13, 1'b0, 1'b0, 2'b00);
        check("size_ignored_beat3", rbuf[3], 32'd3);
`endif

        // Early wlast: all 16 beats accepted, SLVERR response
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0BAD0000 + 32'(i);
        write_burst(32'h200, 4'd15, 4'hF, 7, 0, 6'h09, 3'b010, 1'b1, 2'b10);
        read_burst(32'h200, 4'd15, 3'b010, 6'h0A, 1'b0, 1'b0, 2'b00);
        check("early_wlast_beat15", rbuf[15], 32'h0BAD000F);
        check("wr_bursts_6", wr_bursts, 6);
        check("rd_bursts_7", rd_bursts, 7);

        // Reset during W_DATA after three committed beats
        @(negedge AXI_clk);
        AXI_awaddr = 32'h300; AXI_awid = 6'h01; AXI_awlen = 4'd15; AXI_awvalid = 1'b1;
        @(posedge AXI_clk);
        @(negedge AXI_clk);
        AXI_awvalid = 1'b0;
        check("rstmid_wready", AXI_wready, 1);
        for (int i = 0; i < 3; i++) begin
            AXI_wdata = 32'h77770000 + 32'(i); AXI_wstrb = 4'hF; AXI_wvalid = 1'b1;
            @(posedge AXI_clk);
            exp_mem[10'd192 + 10'(i)] = 32'h77770000 + 32'(i);
            @(negedge AXI_clk);
        end
        AXI_wvalid = 1'b0;
        rst = 1'b1;
        @(posedge AXI_clk);
        @(negedge AXI_clk);
        rst = 1'b0;
        check("rstmid_awready", AXI_awready, 1);
        check("rstmid_wready_low", AXI_wready, 0);
        check("rstmid_bvalid", AXI_bvalid, 0);
        check("rstmid_wr_bursts", wr_bursts, 0);
        check("rstmid_rd_bursts", rd_bursts, 0);
        read_burst(32'h300, 4'd2, 3'b010, 6'h02, 1'b0, 1'b0, 2'b00);
        check("partial_kept", rbuf[2], 32'h77770002);
        check("rd_bursts_after_rst", rd_bursts, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
